// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master AXI-lite arbiter: IFU (read-only) and LSU (read/write) share one
// downstream port. Grant is held until the response handshake; a watchdog
// turns a silent downstream into a decode-error response.
//
// state | meaning
// IDLE  | no grant; arbitrate LSU read > LSU write > IFU read
// IFU_R | IFU AR/R connected to downstream
// LSU_R | LSU AR/R connected to downstream
// LSU_W | LSU AW/W/B connected to downstream
// ERR_R | read aborted; owner sees rresp=DECERR until rready
// ERR_W | write aborted; LSU sees bresp=DECERR until bready, AW/W absorbed
module ysyx_24110015_axi_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    // IFU port
    input  logic [31:0] ifu_s_araddr,
    input  logic [2:0]  ifu_s_arsize,
    input  logic        ifu_s_arvalid,
    output logic        ifu_s_arready,
    output logic [31:0] ifu_s_rdata,
    output logic [1:0]  ifu_s_rresp,
    output logic        ifu_s_rvalid,
    input  logic        ifu_s_rready,
    output logic        ifu_s_awready,
    output logic        ifu_s_wready,
    output logic        ifu_s_bvalid,
    output logic [1:0]  ifu_s_bresp,
    // LSU port
    input  logic [31:0] lsu_s_awaddr,
    input  logic [2:0]  lsu_s_awsize,
    input  logic        lsu_s_awvalid,
    output logic        lsu_s_awready,
    input  logic [31:0] lsu_s_wdata,
    input  logic [3:0]  lsu_s_wstrb,
    input  logic        lsu_s_wvalid,
    output logic        lsu_s_wready,
    output logic [1:0]  lsu_s_bresp,
    output logic        lsu_s_bvalid,
    input  logic        lsu_s_bready,
    input  logic [31:0] lsu_s_araddr,
    input  logic [2:0]  lsu_s_arsize,
    input  logic        lsu_s_arvalid,
    output logic        lsu_s_arready,
    output logic [31:0] lsu_s_rdata,
    output logic [1:0]  lsu_s_rresp,
    output logic        lsu_s_rvalid,
    input  logic        lsu_s_rready,
    // downstream port
    output logic [31:0] mem_m_awaddr,
    output logic [2:0]  mem_m_awsize,
    output logic        mem_m_awvalid,
    input  logic        mem_m_awready,
    output logic [31:0] mem_m_wdata,
    output logic [3:0]  mem_m_wstrb,
    output logic        mem_m_wvalid,
    input  logic        mem_m_wready,
    input  logic [1:0]  mem_m_bresp,
    input  logic        mem_m_bvalid,
    output logic        mem_m_bready,
    output logic [31:0] mem_m_araddr,
    output logic [2:0]  mem_m_arsize,
    output logic        mem_m_arvalid,
    input  logic        mem_m_arready,
    input  logic [31:0] mem_m_rdata,
    input  logic [1:0]  mem_m_rresp,
    input  logic        mem_m_rvalid,
    output logic        mem_m_rready
);

    typedef enum logic [2:0] {IDLE, IFU_R, LSU_R, LSU_W, ERR_R, ERR_W} state_t;

    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    state_t      state, state_next;
    logic [15:0] wdog;
    logic        owner_lsu;
    logic        timeout;

    assign timeout = (wdog == WDOG_LIMIT);

    // State, watchdog and read-owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wdog      <= '0;
            owner_lsu <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IFU_R || state == LSU_R || state == LSU_W)
                wdog <= wdog + 16'd1;
            else
                wdog <= '0;
            // only consulted after a read grant, which IDLE always precedes
            if (state == IDLE)
                owner_lsu <= lsu_s_arvalid;
        end
    end

    // Next-state decode and channel routing
    always_comb begin
        state_next    = state;
        ifu_s_arready = 1'b0;
        ifu_s_rdata   = '0;
        ifu_s_rresp   = '0;
        ifu_s_rvalid  = 1'b0;
        ifu_s_awready = 1'b0;
        ifu_s_wready  = 1'b0;
        ifu_s_bvalid  = 1'b0;
        ifu_s_bresp   = '0;
        lsu_s_awready = 1'b0;
        lsu_s_wready  = 1'b0;
        lsu_s_bresp   = '0;
        lsu_s_bvalid  = 1'b0;
        lsu_s_arready = 1'b0;
        lsu_s_rdata   = '0;
        lsu_s_rresp   = '0;
        lsu_s_rvalid  = 1'b0;
        mem_m_awaddr  = '0;
        mem_m_awsize  = '0;
        mem_m_awvalid = 1'b0;
        mem_m_wdata   = '0;
        mem_m_wstrb   = '0;
        mem_m_wvalid  = 1'b0;
        mem_m_bready  = 1'b0;
        mem_m_araddr  = '0;
        mem_m_arsize  = '0;
        mem_m_arvalid = 1'b0;
        mem_m_rready  = 1'b0;

        case (state)
            IDLE: begin
                if (lsu_s_arvalid)      state_next = LSU_R;
                else if (lsu_s_awvalid) state_next = LSU_W;
                else if (ifu_s_arvalid) state_next = IFU_R;
            end
            IFU_R: begin
                mem_m_araddr  = ifu_s_araddr;
                mem_m_arsize  = ifu_s_arsize;
                mem_m_arvalid = ifu_s_arvalid;
                ifu_s_arready = mem_m_arready;
                ifu_s_rdata   = mem_m_rdata;
                ifu_s_rresp   = mem_m_rresp;
                ifu_s_rvalid  = mem_m_rvalid;
                mem_m_rready  = ifu_s_rready;
                if (mem_m_rvalid && ifu_s_rready) state_next = IDLE;
                else if (timeout)                 state_next = ERR_R;
            end
            LSU_R: begin
                mem_m_araddr  = lsu_s_araddr;
                mem_m_arsize  = lsu_s_arsize;
                mem_m_arvalid = lsu_s_arvalid;
                lsu_s_arready = mem_m_arready;
                lsu_s_rdata   = mem_m_rdata;
                lsu_s_rresp   = mem_m_rresp;
                lsu_s_rvalid  = mem_m_rvalid;
                mem_m_rready  = lsu_s_rready;
                if (mem_m_rvalid && lsu_s_rready) state_next = IDLE;
                else if (timeout)                 state_next = ERR_R;
            end
            LSU_W: begin
                mem_m_awaddr  = lsu_s_awaddr;
                mem_m_awsize  = lsu_s_awsize;
                mem_m_awvalid = lsu_s_awvalid;
                lsu_s_awready = mem_m_awready;
                mem_m_wdata   = lsu_s_wdata;
                mem_m_wstrb   = lsu_s_wstrb;
                mem_m_wvalid  = lsu_s_wvalid;
                lsu_s_wready  = mem_m_wready;
                lsu_s_bresp   = mem_m_bresp;
                lsu_s_bvalid  = mem_m_bvalid;
                mem_m_bready  = lsu_s_bready;
                if (mem_m_bvalid && lsu_s_bready) state_next = IDLE;
                else if (timeout)                 state_next = ERR_W;
            end
            ERR_R: begin
                if (owner_lsu) begin
                    lsu_s_rvalid = 1'b1;
                    lsu_s_rresp  = RESP_DECERR;
                    if (lsu_s_rready) state_next = IDLE;
                end else begin
                    ifu_s_rvalid = 1'b1;
                    ifu_s_rresp  = RESP_DECERR;
                    if (ifu_s_rready) state_next = IDLE;
                end
            end
            ERR_W: begin
                // swallow any AW/W still outstanding so the LSU can move on
                lsu_s_awready = 1'b1;
                lsu_s_wready  = 1'b1;
                lsu_s_bvalid  = 1'b1;
                lsu_s_bresp   = RESP_DECERR;
                if (lsu_s_bready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/ysyx_24110015_axi_arbiter.md
# ysyx_24110015_axi_arbiter

Two-master AXI-lite arbiter between the instruction fetch unit and the load/store unit on one side, and the single memory/peripheral crossbar on the other. It accepts transactions from the IFU (read-only) and the LSU (read and write) and grants the downstream port to one master at a time. The grant is held until that master's response handshake completes. A per-transaction watchdog returns a decode-error response if the downstream side never answers.

## Interface
- `TIMEOUT_CYCLES`, default 1023: cycles a granted transaction may wait for its response before the arbiter aborts it. Legal range is 1..65535.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `ifu_s` axi_lite_if.slave: IFU port. Uses the AR and R channels only (araddr, arsize, arvalid, arready, rdata, rresp, rvalid, rready). Its AW, W and B outputs are tied to 0.
- `lsu_s` axi_lite_if.slave: LSU port, all five channels. Carries awsize/arsize and wstrb.
- `mem_m` axi_lite_if.master: downstream port, all five channels.

## Operation
- States:
  - IDLE
  - IFU_R
  - LSU_R
  - LSU_W
  - ERR_R
  - ERR_W
- Arbitration happens in IDLE only, in fixed priority:
  1. `lsu_s.arvalid` → LSU_R
  2. `lsu_s.awvalid` → LSU_W
  3. `ifu_s.arvalid` → IFU_R
- Simultaneous LSU read and write requests: the read wins.
- In IDLE:
  - All ready and valid outputs toward both masters are 0.
  - All valid outputs toward `mem_m` are 0.
  - `rdata` toward both masters is 0.
- In IFU_R and LSU_R:
  - The granted master's AR and R channels are combinationally connected to `mem_m`: address, size, valid, ready, data, resp.
  - The other master sees 0 on every ready/valid.
- In LSU_W:
  - The LSU's AW, W and B channels are connected to `mem_m`.
  - AW and W may handshake in either order, in any cycles. `lsu_s.wvalid` routinely rises 2 cycles after `awvalid`, and the grant must persist across that gap.
- Completion returns to IDLE on the next edge:
  - IFU_R / LSU_R: `mem_m.rvalid & mem_m.rready`.
  - LSU_W: `mem_m.bvalid & mem_m.bready`.
- Back-to-back transactions: at least one IDLE cycle separates them. No grant is issued on the completion cycle.
- Watchdog:
  - A 16-bit counter clears on entry to any granted state and increments each cycle in that state.
  - When it reaches `TIMEOUT_CYCLES` without completion:
    - LSU_R or IFU_R → ERR_R.
    - LSU_W → ERR_W.
- ERR_R:
  - The downstream port is disconnected; all `mem_m` valid/ready are 0.
  - The granted master sees `rvalid=1`, `rresp=2'b11`, `rdata=0`, held until its `rready`, then IDLE.
  - The granted master is remembered in a 1-bit owner register.
- ERR_W:
  - The downstream port is disconnected.
  - The LSU sees `bvalid=1`, `bresp=2'b11`, held until `bready`, then IDLE.
  - Any not-yet-accepted AW/W is absorbed: awready/wready are forced to 1 toward the LSU in ERR_W.
- Late downstream responses after an abort are ignored. `mem_m.rready` and `mem_m.bready` are held at 0 in IDLE and in the error states.

## Timing
- Reset (synchronous, on the edge with `rst=1`):
  - State = IDLE, watchdog = 0, owner = IFU.
  - Every valid/ready output on all three ports is 0.
  - Every data/resp output is 0.
- Reset mid-transaction: same result on the next edge. No response is delivered to the master.
- Arbitration latency:
  - A request visible in IDLE at edge N is granted at edge N+1.
  - `mem_m.arvalid`/`awvalid` is first asserted in cycle N+1, combinationally from the master's held valid.
  - Masters must hold valid until ready, per AXI.
- Pass-through adds zero cycles on every channel once granted.
- Minimum read round trip through the arbiter: request cycle + 1 grant cycle + downstream latency + 1 return-to-IDLE cycle.
- Watchdog: with `TIMEOUT_CYCLES=T`, the error response is first visible T+1 cycles after the grant edge.

## Test plan
- **IFU read alone:** `ifu_s.arvalid` with `araddr=0x3000_0000`; downstream returns `rdata=0x0000_0413` after 3 cycles → IFU receives `rdata=0x0000_0413`, `rresp=0`. The LSU sees no valid/ready. State returns to IDLE one cycle after the R handshake.
- **LSU write, split W:** `awaddr=0x0f00_0004`, `wdata=0xdead_beef`, `wstrb=4'b1111`, with `wvalid` rising 2 cycles after `awvalid` → `mem_m` receives both unchanged. `bresp=0` reaches the LSU. The IFU `arvalid` asserted during the transaction is granted only after the B handshake plus one IDLE cycle.
- **Contention:** `ifu_s.arvalid` and `lsu_s.arvalid` rise in the same cycle → LSU is granted first, IFU second. Each receives its own `rdata` (0x1111_1111 and 0x2222_2222 respectively).
- **Read timeout:** `TIMEOUT_CYCLES=8`; the downstream never asserts `rvalid` → the IFU gets `rvalid=1`, `rresp=2'b11`, `rdata=0` 9 cycles after the grant. A later downstream `rvalid` is ignored.
- **Write timeout with pending W:** `TIMEOUT_CYCLES=8`; AW accepted, `wready` never asserted → in ERR_W the LSU's W is accepted, then `bresp=2'b11` is delivered, and the state returns to IDLE.
- **Reset mid-read:** `rst` pulsed in LSU_R before `rvalid` → the next cycle shows IDLE with all outputs 0. A fresh IFU read afterwards completes normally.
